// File: rtl/strait_pkg.sv
// Shared types and default sizing for the systolic activation feeder.
// The FSM state enum is used by the feeder top level.
package strait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feed_state_e;

    localparam int DEF_SYSTOLIC_SIZE    = 8;
    localparam int DEF_ACTIVATION_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH       = 4;

endpackage

// File: rtl/act_fifo.sv
// Single-clock, count-based FIFO holding {last, vector} words for the feeder.
// Read data is taken straight from the head slot, so a pop can use it on the same edge.
module act_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even if a pop frees a slot on the same edge.
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds them into a systolic array with a
// one-cycle-per-row diagonal skew; pulses done when the tile's last element leaves row N-1.
module act_skew_feeder
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = DEF_SYSTOLIC_SIZE,
    parameter int ACTIVATION_WIDTH = DEF_ACTIVATION_WIDTH,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] in_act,
    input  logic                                   in_last,
    input  logic                                   scan_en,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out,
    output logic [SYSTOLIC_SIZE-1:0]               row_valid,
    output logic                                   done
);

    localparam int N  = SYSTOLIC_SIZE;
    localparam int AW = ACTIVATION_WIDTH;
    localparam int CW = $clog2(SYSTOLIC_SIZE);

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [N*AW:0] fifo_rd_data;
    feed_state_e   state_q;
    logic [CW-1:0] drain_cnt_q;
    logic          done_q;

    assign in_ready = !fifo_full;
    assign pop      = (state_q != DRAIN) && !fifo_empty && !scan_en;
    assign done     = done_q;

    act_fifo #(
        .WIDTH (N*AW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data ({in_last, in_act}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // DRAIN lasts N-1 edges after the last pop, so done coincides with row N-1 emitting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FEED: begin
                    if (pop) begin
                        state_q     <= fifo_rd_data[N*AW] ? DRAIN : FEED;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == CW'(N-2)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Row r gets a chain of r+1 {valid, data} stages; bubbles carry zero data.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            logic [AW:0] chain_q [0:gi];
            logic [AW:0] stage0_d;

            assign stage0_d = pop ? {1'b1, fifo_rd_data[gi*AW +: AW]} : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j <= gi; j++) chain_q[j] <= '0;
                end else begin
                    chain_q[0] <= stage0_d;
                    for (int j = 1; j <= gi; j++) chain_q[j] <= chain_q[j-1];
                end
            end

            assign act_out[gi*AW +: AW] = chain_q[gi][AW-1:0];
            assign row_valid[gi]        = chain_q[gi][AW];
        end
    endgenerate

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, 8, number of array rows N; legal range 2..32.
REQ-002 SHALL have parameter ACTIVATION_WIDTH, 8, bits per activation AW.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, input vector buffer depth; power of two, 2 or more.
REQ-004 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-005 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, in_act/in_last valid.
REQ-008 SHALL have port in_ready, output, 1, buffer can accept a vector.
REQ-009 SHALL have port in_act, input, N*AW, activation vector; row r in bits [r*AW +: AW].
REQ-010 SHALL have port in_last, input, 1, marks final vector of a tile.
REQ-011 SHALL have port scan_en, input, 1, test mode: stop popping and feed zeros.
REQ-012 SHALL have port act_out, output, N*AW, skewed activations to array row inputs; same packing as in_act.
REQ-013 SHALL have port row_valid, output, N, row r carries a real (popped) element.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when row N-1 outputs the last vector's element.

Function
REQ-015 SHALL accept a vector on any rising edge with in_valid and in_ready both high; in_ready SHALL equal FIFO not full, with no full-bypass.
REQ-016 SHALL ignore in_act and in_last when in_valid is high and in_ready is low; no FIFO state change.
REQ-017 SHALL implement FSM states IDLE, FEED, DRAIN.
REQ-018 SHALL transition IDLE->FEED when the FIFO is non-empty and scan_en is low; the first pop occurs on that same edge.
REQ-019 SHALL pop one vector per edge in FEED while the FIFO is non-empty and scan_en is low; otherwise it SHALL inject a zero vector with valid low (bubble).
REQ-020 SHALL transition FEED->DRAIN on the edge that pops a vector tagged in_last.
REQ-021 In DRAIN, SHALL not pop, SHALL inject zero bubbles, and SHALL still accept input into the FIFO.
REQ-022 SHALL pulse done high for exactly one cycle after edge e+N-1, where e is the edge that popped the last vector, and SHALL return DRAIN->IDLE on that edge.
REQ-023 SHALL apply skew so that the element popped at edge p for row r appears on act_out row r and row_valid[r] after edge p+r, held one cycle; a vector accepted at edge k into an empty FIFO during IDLE/FEED therefore reaches row r after edge k+1+r.
REQ-024 SHALL drive act_out row r to zero whenever row_valid[r] is low.
REQ-025 SHALL not alter values: act_out elements are bit-exact copies with no arithmetic.
REQ-026 SHALL handle simultaneous push and pop on one edge, keeping the FIFO count unchanged.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-028 When scan_en rises mid-tile, SHALL stop popping and shift already-popped elements out normally; SHALL resume popping the edge after scan_en falls, with the FSM state unchanged.

Reset
REQ-029 On rst_n low, SHALL immediately (asynchronously) clear the FSM to IDLE, empty the FIFO, and zero all skew registers.
REQ-030 During and after reset, SHALL hold act_out=0, row_valid=0, done=0, and in_ready=1.
REQ-031 On reset asserted mid-tile, SHALL lose in-flight data with no done pulse.

Structure
REQ-032 SHALL take the FSM state enum and default parameter constants from the shared package strait_pkg.
REQ-033 SHALL implement the buffer as one sub-module, act_fifo: synchronous, single-clock, count-based full/empty; skew chains and FSM SHALL be in the top module.

Verification (N=4, AW=8, FIFO_DEPTH=4)
REQ-034 SHALL cover: single vector {r0..r3}={0x11,0x22,0x33,0x44}, last=1, accepted at edge k -> row r = 0x11*(r+1) after edge k+1+r; done after edge k+4; IDLE after.
REQ-035 SHALL cover: 3 back-to-back vectors, last on 3rd -> each row shows 3 consecutive valid values; rows are offset by 1 cycle; done once.
REQ-036 SHALL cover: FIFO full (4 pushes while scan_en=1) -> in_ready=0; 5th push ignored; after scan_en=0, exactly 4 vectors emerge in order.
REQ-037 SHALL cover: in_valid gaps mid-tile -> row_valid low and act_out zero for bubble cycles; data order preserved.
REQ-038 SHALL cover: rst_n pulsed while row 2 valid -> all outputs 0 asynchronously; in_ready=1; no done.
REQ-039 SHALL cover: push during DRAIN -> vector held, popped on the edge after done, i.e. IDLE->FEED.
